// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared state enum, opcode constants and default widths for alu_arbiter
package alu_arb_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_OPW = 6;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} alu_arb_state_t;
  localparam logic [5:0] ALU_OP_ADDU = 6'b100001;
  localparam logic [5:0] ALU_OP_SUBU = 6'b100011;
  localparam logic [5:0] ALU_OP_AND  = 6'b100100;
  localparam logic [5:0] ALU_OP_OR   = 6'b100101;
  localparam logic [5:0] ALU_OP_SLTU = 6'b101011;
endpackage

// File: rtl/alu_rr_arbiter2.sv
// alu_rr_arbiter2: 2-way round-robin grant (fixed priority to requester 0 when ALU_ARB_FIXED_PRIO_EN is defined)
module alu_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);
`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb grant = {valid[1] & ~valid[0], valid[0]};
`else
  logic last_grant;
  always_comb grant = (&valid) ? (last_grant ? 2'b01 : 2'b10) : valid;
  always_ff @(posedge clk)
    if (rst) last_grant <= 1'b1;
    else if (accept) last_grant <= grant[1];
`endif
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters (ALU_ARB_FIXED_PRIO_EN selects fixed priority)
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OPW   = DEF_OPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero
);
  alu_arb_state_t state;
  logic [1:0] grant;
  logic accept;
  assign accept = (state == IDLE) && (grant != 2'b00);
  assign req0_ready = (state == IDLE) && grant[0];
  assign req1_ready = (state == IDLE) && grant[1];
  assign rsp_valid = (state == RESP);
  alu_rr_arbiter2 u_arb (
    .clk(clk),
    .rst(rst),
    .valid({req1_valid, req0_valid}),
    .accept(accept),
    .grant(grant)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      alu_a <= '0;
      alu_b <= '0;
      alu_control <= '0;
      rsp_id <= 1'b0;
      rsp_result <= '0;
      rsp_zero <= 1'b0;
    end else
      case (state)
        IDLE: if (accept) begin
          alu_a <= grant[1] ? req1_a : req0_a;
          alu_b <= grant[1] ? req1_b : req0_b;
          alu_control <= grant[1] ? req1_op : req0_op;
          rsp_id <= grant[1];
          state <= EXEC;
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero <= alu_zero;
          state <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
  import alu_arb_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [5:0] req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [5:0] alu_control;
  logic alu_zero;
  logic rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [31:0] rsp_result;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );
  always_comb begin
    alu_result = (alu_control == ALU_OP_ADDU) ? alu_a + alu_b :
                 (alu_control == ALU_OP_SUBU) ? alu_a - alu_b :
                 (alu_control == ALU_OP_AND)  ? alu_a & alu_b :
                 (alu_control == ALU_OP_OR)   ? alu_a | alu_b :
                 (alu_control == ALU_OP_SLTU) ? {31'd0, alu_a < alu_b} : 32'd0;
    alu_zero = (alu_result == 32'd0);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    req0_a = 32'd9; req0_b = 32'd4; req0_op = ALU_OP_ADDU; req0_valid = 1'b1;
    tick;
    req0_valid = 1'b0;
    total++; if (alu_a !== 32'd9) $display("FAIL reset_pre_exec_alu_a: got %0h expected 9", alu_a); else passed++;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); else passed++;
    total++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_control !== 6'd0) $display("FAIL reset_alu_regs: got %0h %0h %0h expected 0 0 0", alu_a, alu_b, alu_control); else passed++;
    total++; if (rsp_result !== 32'd0 || rsp_id !== 1'b0 || rsp_zero !== 1'b0) $display("FAIL reset_rsp_regs: got %0h %0b %0b expected 0 0 0", rsp_result, rsp_id, rsp_zero); else passed++;
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL reset_ready_idle: got %0b%0b expected 00", req1_ready, req0_ready); else passed++;
    tick;
    total++; if (rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL reset_stays_idle: got v=%0b r=%0b%0b expected 0 00", rsp_valid, req1_ready, req0_ready); else passed++;
    req1_valid = 1'b1;
    #1;
    total++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) $display("FAIL reset_ready_on_req: got %0b%0b expected 10", req1_ready, req0_ready); else passed++;
    req1_valid = 1'b0;
    #1;
  endtask
  task automatic test_single;
    rsp_ready = 1'b1;
    req0_a = 32'd5; req0_b = 32'd3; req0_op = ALU_OP_SUBU; req0_valid = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL single_ready: got %0b%0b expected 01", req1_ready, req0_ready); else passed++;
    tick;
    req0_valid = 1'b0;
    total++; if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_control !== ALU_OP_SUBU || rsp_valid !== 1'b0) $display("FAIL single_exec: got a=%0h b=%0h op=%0h v=%0b expected 5 3 23 0", alu_a, alu_b, alu_control, rsp_valid); else passed++;
    tick;
    total++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd2 || rsp_zero !== 1'b0 || rsp_id !== 1'b0) $display("FAIL single_rsp: got v=%0b r=%0h z=%0b id=%0b expected 1 2 0 0", rsp_valid, rsp_result, rsp_zero, rsp_id); else passed++;
    tick;
    total++; if (rsp_valid !== 1'b0) $display("FAIL single_back_idle: got %0b expected 0", rsp_valid); else passed++;
  endtask
  task automatic test_zero;
    req1_a = 32'd7; req1_b = 32'd7; req1_op = ALU_OP_SUBU; req1_valid = 1'b1;
    #1;
    total++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) $display("FAIL zero_ready: got %0b%0b expected 10", req1_ready, req0_ready); else passed++;
    tick;
    req1_valid = 1'b0;
    tick;
    total++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b1 || rsp_id !== 1'b1) $display("FAIL zero_rsp: got v=%0b r=%0h z=%0b id=%0b expected 1 0 1 1", rsp_valid, rsp_result, rsp_zero, rsp_id); else passed++;
    tick;
  endtask
  task automatic test_contention;
    logic [7:0] order;
    int c0, c1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    order = 8'b11110000;
`else
    order = 8'b10101010;
`endif
    c0 = 0; c1 = 0;
    rsp_ready = 1'b1;
    req0_a = 32'd1; req0_b = 32'd1; req0_op = ALU_OP_ADDU;
    req1_a = 32'd1; req1_b = 32'd1; req1_op = ALU_OP_ADDU;
    for (int i = 0; i < 8; i++) begin
      req0_valid = (c0 < 4);
      req1_valid = (c1 < 4);
      #1;
      total++; if (req0_ready !== ~order[i] || req1_ready !== order[i]) $display("FAIL contention_grant%0d: got %0b%0b expected id %0b", i, req1_ready, req0_ready, order[i]); else passed++;
      tick;
      if (order[i]) c1++; else c0++;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick;
      total++; if (rsp_valid !== 1'b1 || rsp_id !== order[i] || rsp_result !== 32'd2) $display("FAIL contention_rsp%0d: got v=%0b id=%0b r=%0h expected 1 %0b 2", i, rsp_valid, rsp_id, rsp_result, order[i]); else passed++;
      tick;
    end
  endtask
  task automatic test_backpressure;
    rsp_ready = 1'b0;
    req0_a = 32'hF0; req0_b = 32'h0F; req0_op = ALU_OP_OR; req0_valid = 1'b1;
    tick;
    req0_valid = 1'b0;
    tick;
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (rsp_valid !== 1'b1 || rsp_result !== 32'hFF || rsp_id !== 1'b0 || rsp_zero !== 1'b0) $display("FAIL bp_hold%0d: got v=%0b r=%0h id=%0b z=%0b expected 1 ff 0 0", i, rsp_valid, rsp_result, rsp_id, rsp_zero); else passed++;
      total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || alu_a !== 32'hF0) $display("FAIL bp_ready%0d: got r=%0b%0b a=%0h expected 00 f0", i, req1_ready, req0_ready, alu_a); else passed++;
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    total++; if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) $display("FAIL bp_release: got v=%0b r1=%0b expected 0 1", rsp_valid, req1_ready); else passed++;
    req1_valid = 1'b0;
    #1;
  endtask
  task automatic test_back_to_back;
    rsp_ready = 1'b1;
    req0_a = 32'd3; req0_b = 32'd5; req0_op = ALU_OP_SLTU; req0_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      total++; if (req0_ready !== (i % 3 == 0)) $display("FAIL b2b_accept%0d: got %0b expected %0b", i, req0_ready, i % 3 == 0); else passed++;
      total++; if (rsp_valid !== (i % 3 == 2) || (i % 3 == 2 && rsp_result !== 32'd1)) $display("FAIL b2b_rsp%0d: got v=%0b r=%0h expected %0b 1", i, rsp_valid, rsp_result, i % 3 == 2); else passed++;
      tick;
    end
    req0_valid = 1'b0;
    tick;
  endtask
  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    tick;
    tick;
    rst = 1'b0;
    test_reset;
    test_single;
    test_zero;
    test_contention;
    test_backpressure;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational MIPS ALU between two requesters, such as the execute stage and a multi-cycle helper unit. Each requester hands over one operation (a, b, alu_control) through a valid/ready handshake. The arbiter grants one requester, drives the ALU from registered operands, captures result and zero, and returns them tagged with the requester ID through a valid/ready response channel.

## Interface
- WIDTH, 32, operand/result width
- OPW, 6, alu_control width
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  requester has an operation
- req0_ready / req1_ready  out  1  operation accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- req0_op / req1_op  in  OPW  alu_control code
- alu_a, alu_b  out  WIDTH  to ALU a/b
- alu_control  out  OPW  to ALU alu_control
- alu_result  in  WIDTH  from ALU result
- alu_zero  in  1  from ALU zero
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  0 = requester 0, 1 = requester 1
- rsp_result  out  WIDTH  captured result
- rsp_zero  out  1  captured zero flag

## Operation
- The FSM has three states: IDLE, EXEC, RESP.
- **IDLE:**
  - Grant logic picks one valid requester. Its reqN_ready = 1 combinationally; the other ready = 0.
  - On valid&ready, the arbiter latches a, b, op and the ID, then moves to EXEC.
  - With no valid request, it stays in IDLE.
- **EXEC:** alu_a/alu_b/alu_control come from the latched registers. At the clock edge, alu_result and alu_zero go into the rsp registers and the FSM moves to RESP.
- **RESP:** rsp_valid = 1 and all rsp_* outputs hold stable. On rsp_ready the FSM returns to IDLE. It waits indefinitely otherwise.
- **Ready signals:** both reqN_ready = 0 in EXEC and RESP. Accept happens only in IDLE, so at most one operation is in flight.
- **Round-robin grant:**
  - last_grant register, reset value 1, so requester 0 wins the first tie.
  - When both are valid, grant !last_grant. A single valid requester is always granted.
  - last_grant updates only on an accept.
- **Opcodes:** passed to the ALU unmodified. The arbiter does no decode or checking.
- **Holding valid:** a requester whose valid is not accepted keeps its operands stable. The arbiter does not require this but samples only on accept.
- **Reset values:**
  - FSM = IDLE.
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_zero = 0.
  - alu_a = alu_b = 0, alu_control = 0.
  - last_grant = 1.
- **Reset mid-operation:** the in-flight operation is discarded without a response. One cycle after rst is sampled high, rsp_valid = 0.

## Timing
- Accept in cycle N. ALU is driven in N+1. rsp_valid = 1 in N+2.
- If rsp_ready = 1 in N+2, IDLE is in N+3 and the next accept can happen in N+3. Minimum period is 3 cycles per operation.
- ALU outputs are registered and change only on accept. In IDLE and RESP they hold the last operands.
- The ALU result path is one combinational cycle, from the alu_a register to rsp_result.

## Configuration
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, requester 0 always wins ties. last_grant is not implemented.
- Undefined (default): round-robin as described above.

## Structure
- **alu_arb_pkg:**
  - state enum alu_arb_state_t {IDLE, EXEC, RESP}.
  - Opcode constants ALU_OP_ADDU = 6'b100001, ALU_OP_SUBU = 6'b100011, ALU_OP_AND = 6'b100100, ALU_OP_OR = 6'b100101, ALU_OP_SLTU = 6'b101011.
  - Default widths.
- **Sub-module alu_rr_arbiter2:** 2-way grant logic holding last_grant plus the ALU_ARB_FIXED_PRIO_EN variant. It takes valid[1:0] and accept and outputs grant[1:0].

## Test plan
- **Reset:** assert rst for 2 cycles mid-EXEC → next cycle rsp_valid = 0, all outputs 0, both ready = 0 until a request arrives in IDLE.
- **Single op:** req0 a=5, b=3, op=ALU_OP_SUBU, rsp_ready=1 → rsp_valid 2 cycles after accept, rsp_result=2, rsp_zero=0, rsp_id=0.
- **Zero flag:** req1 a=7, b=7, op=ALU_OP_SUBU → rsp_result=0, rsp_zero=1, rsp_id=1.
- **Contention:** both valid continuously, 4 ops each (ADDU 1+1) → grant order 0,1,0,1… with rsp_result=2 each. With ALU_ARB_FIXED_PRIO_EN the order is 0,0,0,0 until req0 deasserts.
- **Backpressure:** rsp_ready=0 for 5 cycles → rsp_* stable, both ready=0; release → IDLE the next cycle.
- **Back-to-back throughput:** single requester with rsp_ready=1 tied → one accept every 3 cycles exactly.
